// File: rtl/mux_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux_share_arbiter                                             |
// | Purpose  : Round-robin burst arbiter driving a shared 2:1 data select    |
// |            with a valid/ready handshake toward the consumer.             |
// |            Define MUX_SHARE_ARB_FIXED_PRIO_EN for fixed priority (req0). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mux_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    input  logic             out_ready,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic             ack0,
    output logic             ack1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int c_cntW = $clog2(BURST) + 1;
    localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(BURST - 1);

    localparam logic [1:0] c_stIdle = 2'd0;
    localparam logic [1:0] c_stG0   = 2'd1;
    localparam logic [1:0] c_stG1   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_stateNxt;
    logic [c_cntW-1:0] r_cnt;
    logic [c_cntW-1:0] w_cntNxt;
    logic              w_burstEnd;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
    logic              r_last;
    logic              w_lastNxt;
`endif

    assign w_burstEnd = (r_cnt == c_cntLast);

    assign gnt       = {r_state == c_stG1, r_state == c_stG0};
    assign sel       = (r_state == c_stG1);
    assign out_data  = sel ? d1 : d0;
    assign out_valid = (gnt[0] & req0) | (gnt[1] & req1);
    assign ack0      = gnt[0] & req0 & out_ready;
    assign ack1      = gnt[1] & req1 & out_ready;

    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_cnt;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
        w_lastNxt  = r_last;
`endif
        case (r_state)
            c_stIdle: begin
                w_cntNxt = '0;
                if (req0 && req1) begin
`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
                    w_stateNxt = c_stG0;
`else
                    w_stateNxt = r_last ? c_stG0 : c_stG1;
`endif
                end else if (req0) begin
                    w_stateNxt = c_stG0;
                end else if (req1) begin
                    w_stateNxt = c_stG1;
                end
            end
            c_stG0: begin
                if (!req0) begin
                    // Release costs one bubble: this cycle carries no transfer.
                    w_stateNxt = req1 ? c_stG1 : c_stIdle;
                    w_cntNxt   = '0;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
                    w_lastNxt  = 1'b0;
`endif
                end else if (out_ready) begin
                    if (w_burstEnd) begin
                        w_cntNxt = '0;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
                        w_lastNxt = 1'b0;
                        if (req1) begin
                            w_stateNxt = c_stG1;
                        end
`endif
                    end else begin
                        w_cntNxt = r_cnt + 1'b1;
                    end
                end
            end
            c_stG1: begin
                if (!req1) begin
                    w_stateNxt = req0 ? c_stG0 : c_stIdle;
                    w_cntNxt   = '0;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
                    w_lastNxt  = 1'b1;
`endif
                end else if (out_ready) begin
                    if (w_burstEnd) begin
                        w_cntNxt = '0;
`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
                        w_lastNxt = 1'b1;
`endif
                        if (req0) begin
                            w_stateNxt = c_stG0;
                        end
                    end else begin
                        w_cntNxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNxt = c_stIdle;
                w_cntNxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_stIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_cnt   <= w_cntNxt;
        end
    end

`ifndef MUX_SHARE_ARB_FIXED_PRIO_EN
    // last=1 after reset so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_lastNxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux_share_arbiter                                          |
// | Purpose  : Self-checking bench; transfer scoreboard plus scenario tasks. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mux_share_arbiter;

    localparam int WIDTH = 32;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, out_ready;
    logic [WIDTH-1:0] d0, d1;
    logic [1:0]       gnt;
    logic             sel, ack0, ack1, out_valid;
    logic [WIDTH-1:0] out_data;

    int nTests = 0;
    int nFail  = 0;
    logic advance = 1'b0;
    logic [WIDTH:0] sbQ[$];

    mux_share_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
        .out_ready(out_ready), .gnt(gnt), .sel(sel), .ack0(ack0), .ack1(ack1),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // One clock: check any transfer against the scoreboard, then let the
    // requesters move to their next word if they were acked.
    task automatic tick();
        logic adv0, adv1;
        logic [WIDTH:0] expV, gotV;
        adv0 = 1'b0;
        adv1 = 1'b0;
        @(negedge clk);
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            nTests++;
            gotV = {ack1, out_data};
            if (ack0 === 1'b1 && ack1 === 1'b1) begin
                nFail++;
                $display("FAIL ack_both: ack0=%b ack1=%b, required one-hot", ack0, ack1);
            end else if (sbQ.size() == 0) begin
                nFail++;
                $display("FAIL sb_unexpected: got side=%0d data=%h, required no transfer", gotV[WIDTH], gotV[WIDTH-1:0]);
            end else begin
                expV = sbQ.pop_front();
                if (gotV !== expV) begin
                    nFail++;
                    $display("FAIL sb_xfer: got side=%0d data=%h, required side=%0d data=%h",
                             gotV[WIDTH], gotV[WIDTH-1:0], expV[WIDTH], expV[WIDTH-1:0]);
                end
            end
            adv0 = ack0;
            adv1 = ack1;
        end
        @(posedge clk);
        #1;
        if (advance) begin
            if (adv0) d0 = d0 + 1;
            if (adv1) d1 = d1 + 1;
        end
        #1;
    endtask

    task automatic sb_empty(input string name);
        nTests++;
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL %s_drain: %0d transfers outstanding, required 0", name, sbQ.size());
        end
        sbQ.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; advance = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b0;
        d0 = 32'h1000_0000; d1 = 32'h2000_0000;
        @(posedge clk);
        #1;
        nTests += 4;
        if (gnt !== 2'b00) begin nFail++; $display("FAIL rst_gnt: got %b, required 00", gnt); end
        if (sel !== 1'b0) begin nFail++; $display("FAIL rst_sel: got %b, required 0", sel); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        if (out_data !== 32'h1000_0000) begin nFail++; $display("FAIL rst_data: got %h, required 10000000", out_data); end
        reset = 1'b0;
        tick();
        nTests += 3;
        if (gnt !== 2'b01) begin nFail++; $display("FAIL rel_gnt: got %b, required 01", gnt); end
        if (out_data !== 32'h1000_0000) begin nFail++; $display("FAIL rel_data: got %h, required 10000000", out_data); end
        if (out_valid !== 1'b1) begin nFail++; $display("FAIL rel_valid: got %b, required 1", out_valid); end
    endtask

    task automatic test_reset_mid_g1();
        do_reset();
        req1 = 1'b1;
        tick();
        nTests++;
        if (gnt !== 2'b10) begin nFail++; $display("FAIL midrst_pre_gnt: got %b, required 10", gnt); end
        #2 reset = 1'b1;
        #1;
        nTests += 3;
        if (gnt !== 2'b00) begin nFail++; $display("FAIL midrst_gnt: got %b, required 00", gnt); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
        if (ack1 !== 1'b0) begin nFail++; $display("FAIL midrst_ack1: got %b, required 0", ack1); end
        reset = 1'b0;
    endtask

    task automatic test_single_req1();
        do_reset();
        req1 = 1'b1; out_ready = 1'b1; d1 = 32'hA5A5_A5A5;
        #1;
        nTests++;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL s1_idle_valid: got %b, required 0", out_valid); end
        tick();
        for (int i = 0; i < 10; i++) begin
            sbQ.push_back({1'b1, 32'hA5A5_A5A5});
            nTests += 3;
            if (gnt !== 2'b10) begin nFail++; $display("FAIL s1_gnt[%0d]: got %b, required 10", i, gnt); end
            if (sel !== 1'b1) begin nFail++; $display("FAIL s1_sel[%0d]: got %b, required 1", i, sel); end
            if (ack1 !== 1'b1) begin nFail++; $display("FAIL s1_ack1[%0d]: got %b, required 1", i, ack1); end
            tick();
        end
        sb_empty("s1");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] n0, n1;
        do_reset();
        advance = 1'b1;
        d0 = 32'h100; d1 = 32'h200;
        n0 = 32'h100; n1 = 32'h200;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (((i / BURST) % 2) == 0) begin sbQ.push_back({1'b0, n0}); n0++; end
            else begin sbQ.push_back({1'b1, n1}); n1++; end
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            nTests += 2;
            if (out_valid !== 1'b1) begin nFail++; $display("FAIL b2b_valid[%0d]: got %b, required 1", i, out_valid); end
            if (sel !== 1'((i / BURST) % 2)) begin nFail++; $display("FAIL b2b_sel[%0d]: got %b, required %0d", i, sel, (i / BURST) % 2); end
            tick();
        end
        sb_empty("b2b");
    endtask

    task automatic test_fixed_prio();
        do_reset();
        advance = 1'b1;
        d0 = 32'h500; d1 = 32'h600;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) sbQ.push_back({1'b0, 32'h500 + 32'(i)});
        tick();
        for (int i = 0; i < 20; i++) begin
            nTests += 2;
            if (gnt !== 2'b01) begin nFail++; $display("FAIL fp_gnt[%0d]: got %b, required 01", i, gnt); end
            if (ack1 !== 1'b0) begin nFail++; $display("FAIL fp_ack1[%0d]: got %b, required 0", i, ack1); end
            tick();
        end
        sb_empty("fp");
    endtask

    task automatic test_stall();
        logic [1:0] expGnt;
        do_reset();
        req0 = 1'b1; out_ready = 1'b1; d0 = 32'h1234_5678; d1 = 32'hCAFE_0001;
        sbQ.push_back({1'b0, 32'h1234_5678});
        tick();
        tick();
        out_ready = 1'b0; req1 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            nTests += 4;
            if (out_valid !== 1'b1) begin nFail++; $display("FAIL st_valid[%0d]: got %b, required 1", i, out_valid); end
            if (out_data !== 32'h1234_5678) begin nFail++; $display("FAIL st_data[%0d]: got %h, required 12345678", i, out_data); end
            if (gnt !== 2'b01) begin nFail++; $display("FAIL st_gnt[%0d]: got %b, required 01", i, gnt); end
            if (ack0 !== 1'b0) begin nFail++; $display("FAIL st_ack0[%0d]: got %b, required 0", i, ack0); end
            tick();
        end
        // Three more beats complete the burst only if the count was frozen.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) sbQ.push_back({1'b0, 32'h1234_5678});
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        #1;
`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
        expGnt = 2'b01;
`else
        expGnt = 2'b10;
`endif
        nTests++;
        if (gnt !== expGnt) begin nFail++; $display("FAIL st_burst_end_gnt: got %b, required %b", gnt, expGnt); end
        sb_empty("st");
    endtask

    task automatic test_release();
        do_reset();
        advance = 1'b1;
        d0 = 32'h300; d1 = 32'h400;
        req0 = 1'b1; out_ready = 1'b1;
        sbQ.push_back({1'b0, 32'h300});
        sbQ.push_back({1'b0, 32'h301});
        tick();
        tick();
        tick();
        req0 = 1'b0; req1 = 1'b1;
        #1;
        nTests += 3;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL rl_bubble_valid: got %b, required 0", out_valid); end
        if (gnt !== 2'b01) begin nFail++; $display("FAIL rl_bubble_gnt: got %b, required 01", gnt); end
        if (ack0 !== 1'b0) begin nFail++; $display("FAIL rl_bubble_ack0: got %b, required 0", ack0); end
        tick();
        nTests += 2;
        if (gnt !== 2'b10) begin nFail++; $display("FAIL rl_gnt: got %b, required 10", gnt); end
        if (out_valid !== 1'b1) begin nFail++; $display("FAIL rl_valid: got %b, required 1", out_valid); end
        sbQ.push_back({1'b1, 32'h400});
        tick();
        sb_empty("rl");
    endtask

    initial begin
        test_reset();
        test_reset_mid_g1();
        test_single_req1();
`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_back_to_back();
`endif
        test_stall();
        test_release();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
